peripheral_ahb4_master: RTL and testbench

Single-transfer AMBA AHB-Lite initiator that turns a simple valid/ready request interface into non-pipelined AHB-Lite read/write transfers. It is the bus-master end for the AHB4 single-port RAM slave and other AHB4 peripherals, used by test harnesses and small DMA/boot engines in the SoC. It handles slave wait states and the two-cycle ERROR response. It returns one response per request.

---
 rtl/peripheral_ahb4_master_if.sv | 45 ++++
 rtl/peripheral_ahb4_master.sv | 151 +++++++++++++++
 tb/tb_peripheral_ahb4_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_ahb4_master_if.sv
// Request/response and AHB-Lite bus bundle for the single-transfer AHB4 initiator.
// Ports: req_* / rsp_* requester handshake, H* AHB-Lite initiator signals;
// modport master = initiator view, modport slave = requester + bus-fabric view.
interface peripheral_ahb4_master_if #(
    parameter int PLEN = 8,
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [PLEN-1:0] req_addr;
    logic [2:0]      req_size;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_error;
    logic            HSEL;
    logic [PLEN-1:0] HADDR;
    logic [XLEN-1:0] HWDATA;
    logic [XLEN-1:0] HRDATA;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [2:0]      HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;
    logic            HMASTLOCK;
    logic            HREADY;
    logic            HRESP;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        output HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE,
        input  HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/peripheral_ahb4_master.sv
// Single-transfer AHB-Lite initiator: one valid/ready request becomes one
// non-pipelined AHB read/write transfer and produces one response pulse.
// Ports: HCLK, HRESET (async, active-high), bus (peripheral_ahb4_master_if.master).
module peripheral_ahb4_master #(
    parameter int PLEN = 8,
    parameter int XLEN = 32
) (
    input logic                      HCLK,
    input logic                      HRESET,
    peripheral_ahb4_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REJECT
    } state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    state_t          state_q, state_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_error_q, rsp_error_d;
    logic            hsel_q, hsel_d;
    logic [PLEN-1:0] haddr_q, haddr_d;
    logic [XLEN-1:0] hwdata_q, hwdata_d;
    logic            hwrite_q, hwrite_d;
    logic [2:0]      hsize_q, hsize_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            bad_req;

    // Oversized or misaligned requests never reach the bus.
    always_comb begin
        bad_req = 1'b0;
        if (bus.req_size > 3'd2) begin
            bad_req = 1'b1;
        end else if (bus.req_size == 3'd1 && bus.req_addr[0]) begin
            bad_req = 1'b1;
        end else if (bus.req_size == 3'd2 && bus.req_addr[1:0] != 2'b00) begin
            bad_req = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = 1'b0;
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        htrans_d    = htrans_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    // The H* address registers double as the request latch.
                    haddr_d  = bus.req_addr;
                    hsize_d  = bus.req_size;
                    hwrite_d = bus.req_write;
                    wdata_d  = bus.req_wdata;
                    if (bad_req) begin
                        state_d = S_REJECT;
                    end else begin
                        state_d  = S_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = TR_NONSEQ;
                    end
                end
            end
            S_ADDR: begin
                if (bus.HREADY) begin
                    state_d  = S_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = TR_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                end
            end
            S_DATA: begin
                // HREADY low (with or without HRESP) just extends the phase;
                // an ERROR completes on its second cycle and is never retried.
                if (bus.HREADY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = bus.HRESP;
                    rsp_rdata_d = (!hwrite_q && !bus.HRESP) ? bus.HRDATA : '0;
                    hwdata_d    = '0;
                end
            end
            S_REJECT: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b1;
                rsp_rdata_d = '0;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            htrans_q    <= TR_IDLE;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            htrans_q    <= htrans_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.HSEL      = hsel_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = 4'b0011;
    assign bus.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_peripheral_ahb4_master.sv
// Directed bench for peripheral_ahb4_master against a small AHB SPRAM model
// with programmable data-phase wait states and two-cycle ERROR injection.
module tb_peripheral_ahb4_master;

    logic HCLK;
    logic HRESET;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    peripheral_ahb4_master_if #(.PLEN(8), .XLEN(32)) bus ();

    peripheral_ahb4_master #(.PLEN(8), .XLEN(32)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- SPRAM slave model ----------------
    logic [31:0] mem [0:63];
    logic        s_act;
    logic [7:0]  s_addr;
    logic        s_wr;
    logic [2:0]  s_sz;
    int          s_wait;
    logic        s_err;
    logic        s_estep;
    int          cfg_waits;
    logic        cfg_err;
    logic        s_hready;
    logic        s_hresp;
    logic [31:0] s_hrdata;

    function automatic logic [31:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
        logic [31:0] m;
        case (sz)
            3'd0:    m = 32'h0000_00FF << {a, 3'b000};
            3'd1:    m = 32'h0000_FFFF << {a, 3'b000};
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

    always_comb begin
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        s_hrdata = 32'h0;
        if (s_act) begin
            if (s_err) begin
                s_hresp  = 1'b1;
                s_hready = s_estep;
            end else begin
                s_hready = (s_wait == 0);
                if (!s_wr && s_wait == 0) begin
                    s_hrdata = mem[s_addr[7:2]] & lane_mask(s_sz, s_addr[1:0]);
                end
            end
        end
    end

    assign bus.HREADY = s_hready;
    assign bus.HRESP  = s_hresp;
    assign bus.HRDATA = s_hrdata;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_act   <= 1'b0;
            s_addr  <= 8'h0;
            s_wr    <= 1'b0;
            s_sz    <= 3'd0;
            s_wait  <= 0;
            s_err   <= 1'b0;
            s_estep <= 1'b0;
        end else if (s_act) begin
            if (s_err) begin
                if (!s_estep) s_estep <= 1'b1;
                else          s_act   <= 1'b0;
            end else if (s_wait > 0) begin
                s_wait <= s_wait - 1;
            end else begin
                if (s_wr) begin
                    mem[s_addr[7:2]] <= (mem[s_addr[7:2]] & ~lane_mask(s_sz, s_addr[1:0]))
                                      | (bus.HWDATA & lane_mask(s_sz, s_addr[1:0]));
                end
                s_act <= 1'b0;
            end
        end else if (bus.HSEL && bus.HTRANS == 2'b10 && s_hready) begin
            s_act   <= 1'b1;
            s_addr  <= bus.HADDR;
            s_wr    <= bus.HWRITE;
            s_sz    <= bus.HSIZE;
            s_wait  <= cfg_waits;
            s_err   <= cfg_err;
            s_estep <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One request; returns response fields, cycles from accept to rsp_valid
    // and the number of NONSEQ cycles seen.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat, output int ns);
        bit got;
        bit bad_a;
        bit bad_d;
        int k;
        @(negedge HCLK);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_size  = sz;
        bus.req_wdata = wd;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge HCLK);
            k++;
        end
        if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        lat = 0; ns = 0; got = 0; bad_a = 0; bad_d = 0;
        rd = 32'hx; er = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge HCLK);
            lat = i;
            if (bus.HTRANS == 2'b10) begin
                ns++;
                if (bus.HSEL !== 1'b1 || bus.HWRITE !== w || bus.HSIZE !== sz) bad_a = 1;
            end
            if ((bus.HTRANS == 2'b10 || s_act) && bus.HADDR !== a) bad_a = 1;
            if (s_act && bus.HWDATA !== (w ? wd : 32'h0)) bad_d = 1;
            if (bus.rsp_valid) begin
                rd  = bus.rsp_rdata;
                er  = bus.rsp_error;
                got = 1;
                break;
            end
        end
        if (!got) chk("rsp_timeout", 32'd0, 32'd1);
        chk("addr_phase", {31'd0, bad_a}, 32'd0);
        chk("hwdata", {31'd0, bad_d}, 32'd0);
    endtask

    task automatic idle_watch(input int n, output int rv, output int ns);
        rv = 0; ns = 0;
        repeat (n) begin
            @(negedge HCLK);
            if (bus.rsp_valid) rv++;
            if (bus.HTRANS != 2'b00) ns++;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          ns;
    int          rv;
    int          acc [4];
    logic [31:0] b2b_exp [4];
    bit          got_r;

    initial begin
        b2b_exp[0] = 32'h0000_0011;
        b2b_exp[1] = 32'h0000_2200;
        b2b_exp[2] = 32'h0033_0000;
        b2b_exp[3] = 32'h4400_0000;
        HRESET        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h0;
        bus.req_size  = 3'd0;
        bus.req_wdata = 32'h0;
        cfg_waits     = 0;
        cfg_err       = 1'b0;
        #3;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_error", {31'd0, bus.rsp_error}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_hsel", {31'd0, bus.HSEL}, 32'd0);
        chk("rst_htrans", {30'd0, bus.HTRANS}, 32'd0);
        chk("rst_haddr", {24'd0, bus.HADDR}, 32'd0);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_hwrite_hsize", {28'd0, bus.HWRITE, bus.HSIZE}, 32'd0);
        chk("rst_hburst", {29'd0, bus.HBURST}, 32'd0);
        chk("rst_hprot", {28'd0, bus.HPROT}, 32'h3);
        chk("rst_hmastlock", {31'd0, bus.HMASTLOCK}, 32'd0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // zero-wait word write then read
        xfer(1'b1, 8'h10, 3'd2, 32'hDEAD_BEEF, rd, er, lat, ns);
        chk("wr_err", {31'd0, er}, 32'd0);
        chk("wr_lat", lat, 32'd3);
        chk("wr_nonseq", ns, 32'd1);
        chk("wr_rdata", rd, 32'd0);
        xfer(1'b0, 8'h10, 3'd2, 32'h0, rd, er, lat, ns);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err", {31'd0, er}, 32'd0);
        chk("rd_lat", lat, 32'd3);

        // read with 3 data-phase wait states
        xfer(1'b1, 8'h20, 3'd2, 32'hCAFE_F00D, rd, er, lat, ns);
        chk("wr20_lat", lat, 32'd3);
        cfg_waits = 3;
        xfer(1'b0, 8'h20, 3'd2, 32'h0, rd, er, lat, ns);
        cfg_waits = 0;
        chk("wait_data", rd, 32'hCAFE_F00D);
        chk("wait_lat", lat, 32'd6);
        chk("wait_nonseq", ns, 32'd1);

        // two-cycle ERROR response on a write
        cfg_err = 1'b1;
        xfer(1'b1, 8'h40, 3'd2, 32'h1234_5678, rd, er, lat, ns);
        cfg_err = 1'b0;
        chk("err_err", {31'd0, er}, 32'd1);
        chk("err_rdata", rd, 32'd0);
        chk("err_lat", lat, 32'd4);
        chk("err_nonseq", ns, 32'd1);
        idle_watch(4, rv, ns);
        chk("err_no_2nd_rsp", rv, 32'd0);
        chk("err_no_retry", ns, 32'd0);

        // rejects: misaligned half, oversized size code
        xfer(1'b0, 8'h10, 3'd2, 32'h0, rd, er, lat, ns);
        chk("pre_rej_data", rd, 32'hDEAD_BEEF);
        xfer(1'b1, 8'h03, 3'd1, 32'hAAAA_5555, rd, er, lat, ns);
        chk("rej_half_err", {31'd0, er}, 32'd1);
        chk("rej_half_lat", lat, 32'd2);
        chk("rej_half_nonseq", ns, 32'd0);
        chk("rej_half_rdata", rd, 32'd0);
        xfer(1'b0, 8'h00, 3'd3, 32'h0, rd, er, lat, ns);
        chk("rej_size_err", {31'd0, er}, 32'd1);
        chk("rej_size_lat", lat, 32'd2);
        chk("rej_size_nonseq", ns, 32'd0);

        // back-to-back byte reads with req_valid held high
        xfer(1'b1, 8'h00, 3'd2, 32'h4433_2211, rd, er, lat, ns);
        chk("pre_b2b_err", {31'd0, er}, 32'd0);
        @(negedge HCLK);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 3'd0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            bus.req_addr = i[7:0];
            @(posedge HCLK);
            #1;
            acc[i] = cyc;
            @(negedge HCLK);
            chk("b2b_hsize", {29'd0, bus.HSIZE}, 32'd0);
            chk("b2b_haddr", {24'd0, bus.HADDR}, i);
            got_r = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge HCLK);
                if (bus.rsp_valid) begin
                    got_r = 1;
                    break;
                end
            end
            chk("b2b_rsp_seen", {31'd0, got_r}, 32'd1);
            chk("b2b_rdata", bus.rsp_rdata, b2b_exp[i]);
            chk("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
        end
        bus.req_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("b2b_gap", acc[i] - acc[i-1], 32'd3);
        end

        // reset during the data phase of a read
        cfg_waits = 5;
        @(negedge HCLK);
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h10;
        bus.req_size  = 3'd2;
        @(posedge HCLK);
        #1;
        bus.req_valid = 1'b0;
        @(negedge HCLK);
        chk("rst_mid_nonseq", {30'd0, bus.HTRANS}, 32'h2);
        @(negedge HCLK);
        chk("rst_mid_busy", {31'd0, bus.req_ready}, 32'd0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_mid_htrans", {30'd0, bus.HTRANS}, 32'd0);
        chk("rst_mid_hsel", {31'd0, bus.HSEL}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd1);
        idle_watch(2, rv, ns);
        chk("rst_mid_no_rsp", rv, 32'd0);
        HRESET = 1'b0;
        cfg_waits = 0;
        idle_watch(3, rv, ns);
        chk("rst_post_no_rsp", rv, 32'd0);
        chk("rst_post_idle", ns, 32'd0);
        xfer(1'b0, 8'h10, 3'd2, 32'h0, rd, er, lat, ns);
        chk("rst_post_data", rd, 32'hDEAD_BEEF);
        chk("rst_post_lat", lat, 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
